hpm_window_detector: RTL and testbench



---
 rtl/hpm_window_detector.sv | 195 +++++++++++++++++++
 tb/tb_hpm_window_detector.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hpm_window_detector.sv
// Responder side of the HPM tracer handshake: snapshots the counter bank on enable_detect,
// checks one counter per cycle against its [lo,hi] bounds, then publishes a held verdict.
module hpm_window_detector #(
  parameter int NUM_HPM   = 13,
  parameter int ALARM_MIN = 1
) (
  input  logic                clk_h,
  input  logic                rst_h,
  input  logic                enable_detect,
  input  logic [32*64-1:0]    hpm_in,
  input  logic [1:0]          target,
  output logic                end_detect,
  output logic                busy,
  output logic                alarm,
  output logic [NUM_HPM-1:0]  viol_mask,
  output logic [5:0]          viol_count,
  output logic [1:0]          alarm_target,
  output logic [15:0]         windows_seen,
  input  logic                cfg_we,
  input  logic [4:0]          cfg_idx,
  input  logic [31:0]         cfg_lo,
  input  logic [31:0]         cfg_hi,
  input  logic                cfg_en,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2,
    S_REL  = 2'd3
  } state_t;

  localparam logic [5:0] LAST_IDX = 6'(NUM_HPM);

  state_t state_q, state_d;
  logic [5:0] idx_q, idx_d;
  logic start, commit, scan_step, cfg_ok;

  logic [31:0] lo_q [NUM_HPM];
  logic [31:0] hi_q [NUM_HPM];
  logic        en_q [NUM_HPM];
  logic [63:0] snap_hpm_q [NUM_HPM];
  logic [31:0] snap_lo_q  [NUM_HPM];
  logic [31:0] snap_hi_q  [NUM_HPM];
  logic        snap_en_q  [NUM_HPM];
  logic [1:0]  tgt_q;
  logic [NUM_HPM-1:0] acc_q;

  logic               end_q, alarm_q;
  logic [NUM_HPM-1:0] mask_q;
  logic [5:0]         count_q;
  logic [1:0]         alarm_target_q;
  logic [15:0]        windows_q;

  logic [63:0] cur_hpm;
  logic [31:0] cur_lo, cur_hi, cur_val;
  logic        cur_en, viol;
  logic [5:0]  pop;

  if (NUM_HPM < 32) begin : g_unused
    logic unused_hpm;
    assign unused_hpm = ^hpm_in[32*64-1:NUM_HPM*64];
  end

  always_ff @(posedge clk_h or negedge rst_h) begin
    if (!rst_h) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // The SCAN state spends one extra edge at idx==NUM_HPM to commit the verdict.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    start     = 1'b0;
    commit    = 1'b0;
    scan_step = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable_detect) begin
          state_d = S_SCAN;
          idx_d   = '0;
          start   = 1'b1;
        end
      end
      S_SCAN: begin
        if (idx_q == LAST_IDX) begin
          commit  = 1'b1;
          state_d = S_DONE;
        end else begin
          scan_step = 1'b1;
          idx_d     = idx_q + 6'd1;
        end
      end
      S_DONE:  state_d = enable_detect ? S_REL : S_IDLE;
      S_REL:   if (!enable_detect) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign cfg_ok = (state_q == S_IDLE) && cfg_we;

  always_comb begin
    cur_hpm = '0;
    cur_lo  = '0;
    cur_hi  = '1;
    cur_en  = 1'b0;
    for (int i = 0; i < NUM_HPM; i++) begin
      if (idx_q == 6'(i)) begin
        cur_hpm = snap_hpm_q[i];
        cur_lo  = snap_lo_q[i];
        cur_hi  = snap_hi_q[i];
        cur_en  = snap_en_q[i];
      end
    end
    cur_val = (cur_hpm[63:32] != 32'd0) ? 32'hFFFF_FFFF : cur_hpm[31:0];
    viol    = cur_en && ((cur_val < cur_lo) || (cur_val > cur_hi));
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_HPM; i++) pop = pop + {5'd0, acc_q[i]};
  end

  // Bounds are copied alongside the counters so a write on the trigger edge only affects later scans.
  always_ff @(posedge clk_h or negedge rst_h) begin
    if (!rst_h) begin
      for (int i = 0; i < NUM_HPM; i++) begin
        lo_q[i]       <= '0;
        hi_q[i]       <= '1;
        en_q[i]       <= 1'b0;
        snap_hpm_q[i] <= '0;
        snap_lo_q[i]  <= '0;
        snap_hi_q[i]  <= '1;
        snap_en_q[i]  <= 1'b0;
      end
      tgt_q          <= '0;
      acc_q          <= '0;
      end_q          <= 1'b0;
      alarm_q        <= 1'b0;
      mask_q         <= '0;
      count_q        <= '0;
      alarm_target_q <= '0;
      windows_q      <= '0;
    end else begin
      end_q <= commit;
      if (cfg_ok) begin
        for (int i = 0; i < NUM_HPM; i++) begin
          if (cfg_idx == 5'(i)) begin
            lo_q[i] <= cfg_lo;
            hi_q[i] <= cfg_hi;
            en_q[i] <= cfg_en;
          end
        end
      end
      if (start) begin
        for (int i = 0; i < NUM_HPM; i++) begin
          snap_hpm_q[i] <= hpm_in[i*64 +: 64];
          snap_lo_q[i]  <= lo_q[i];
          snap_hi_q[i]  <= hi_q[i];
          snap_en_q[i]  <= en_q[i];
        end
        tgt_q <= target;
        acc_q <= '0;
      end
      if (scan_step) begin
        for (int i = 0; i < NUM_HPM; i++) begin
          if (idx_q == 6'(i)) acc_q[i] <= viol;
        end
      end
      if (commit) begin
        mask_q         <= acc_q;
        count_q        <= pop;
        alarm_q        <= (pop >= 6'(ALARM_MIN));
        alarm_target_q <= tgt_q;
        if (windows_q != 16'hFFFF) windows_q <= windows_q + 16'd1;
      end
    end
  end

  assign end_detect   = end_q;
  assign busy         = (state_q != S_IDLE);
  assign alarm        = alarm_q;
  assign viol_mask    = mask_q;
  assign viol_count   = count_q;
  assign alarm_target = alarm_target_q;
  assign windows_seen = windows_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_hpm_window_detector.sv
// Directed plus randomized bench for hpm_window_detector; expected verdicts come from
// a bound-table model evaluated with plain arithmetic when each window is launched.
module tb_hpm_window_detector;
  localparam int N = 13;

  // Clock and reset
  logic clk_h = 1'b0;
  always #5 clk_h = ~clk_h;
  logic rst_h = 1'b0;

  logic               enable_detect = 1'b0;
  logic [32*64-1:0]   hpm_in = '0;
  logic [1:0]         target = '0;
  logic               end_detect, busy, alarm;
  logic [N-1:0]       viol_mask;
  logic [5:0]         viol_count;
  logic [1:0]         alarm_target;
  logic [15:0]        windows_seen;
  logic               cfg_we = 1'b0;
  logic [4:0]         cfg_idx = '0;
  logic [31:0]        cfg_lo = '0;
  logic [31:0]        cfg_hi = '0;
  logic               cfg_en = 1'b0;
  logic [1:0]         dbg_state;

  hpm_window_detector #(.NUM_HPM(N), .ALARM_MIN(1)) dut (
    .clk_h(clk_h), .rst_h(rst_h), .enable_detect(enable_detect), .hpm_in(hpm_in),
    .target(target), .end_detect(end_detect), .busy(busy), .alarm(alarm),
    .viol_mask(viol_mask), .viol_count(viol_count), .alarm_target(alarm_target),
    .windows_seen(windows_seen), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_lo(cfg_lo),
    .cfg_hi(cfg_hi), .cfg_en(cfg_en), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int end_cnt = 0;

  always @(negedge clk_h) if (rst_h && end_detect) end_cnt++;

  // Reference model: bound table, counter values, scoreboard
  logic [31:0] lo_m [N];
  logic [31:0] hi_m [N];
  logic        en_m [N];
  logic [63:0] hpm_v [N];
  int          windows_m = 0;
  logic [N-1:0] exp_q[$];
  logic [1:0]   exp_tgt_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < N; i++) begin
      lo_m[i] = 32'd0;
      hi_m[i] = 32'hFFFF_FFFF;
      en_m[i] = 1'b0;
    end
    windows_m = 0;
  endtask

  function automatic logic [N-1:0] predict();
    logic [N-1:0] m;
    longint unsigned v;
    m = '0;
    for (int i = 0; i < N; i++) begin
      v = hpm_v[i];
      if (v > 64'h0000_0000_FFFF_FFFF) v = 64'h0000_0000_FFFF_FFFF;
      m[i] = en_m[i] && ((v < longint'(lo_m[i])) || (v > longint'(hi_m[i])));
    end
    return m;
  endfunction

  // Driver tasks
  task automatic cfg_write(input int idx, input logic [31:0] lo, input logic [31:0] hi,
                           input logic en);
    @(negedge clk_h);
    cfg_we = 1'b1; cfg_idx = 5'(idx); cfg_lo = lo; cfg_hi = hi; cfg_en = en;
    @(negedge clk_h);
    cfg_we = 1'b0;
    if (idx < N) begin
      lo_m[idx] = lo; hi_m[idx] = hi; en_m[idx] = en;
    end
  endtask

  // Launches one window, holds enable_detect for 'hold' cycles after E0, checks
  // latency and the committed verdict. Optional cfg write on E0 or during the scan.
  task automatic run_window(input string tag, input logic [1:0] tgt, input int hold,
                            input bit cfg_e0, input bit cfg_mid, input int c_idx,
                            input logic [31:0] c_lo, input logic [31:0] c_hi, input logic c_en);
    logic [N-1:0] m;
    int cyc;
    int ends_before;
    bit got;
    ends_before = end_cnt;
    @(negedge clk_h);
    for (int i = 0; i < N; i++) hpm_in[i*64 +: 64] = hpm_v[i];
    target = tgt;
    enable_detect = 1'b1;
    exp_q.push_back(predict());
    exp_tgt_q.push_back(tgt);
    if (cfg_e0) begin
      cfg_we = 1'b1; cfg_idx = 5'(c_idx); cfg_lo = c_lo; cfg_hi = c_hi; cfg_en = c_en;
      if (c_idx < N) begin
        lo_m[c_idx] = c_lo; hi_m[c_idx] = c_hi; en_m[c_idx] = c_en;
      end
    end
    @(negedge clk_h);
    cfg_we = 1'b0;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    hpm_in = '1;
    target = ~tgt;
    if (hold <= 1) enable_detect = 1'b0;
    cyc = 0;
    got = 0;
    while (!got && cyc < 40) begin
      if (cfg_mid && cyc == 3) begin
        cfg_we = 1'b1; cfg_idx = 5'(c_idx); cfg_lo = c_lo; cfg_hi = c_hi; cfg_en = c_en;
      end else begin
        cfg_we = 1'b0;
      end
      @(negedge clk_h);
      cyc++;
      if (cyc >= hold) enable_detect = 1'b0;
      if (end_detect) got = 1;
    end
    cfg_we = 1'b0;
    check({tag, "_latency"}, 64'(cyc), 64'd14);
    m = exp_q.pop_front();
    if (windows_m < 16'hFFFF) windows_m++;
    check({tag, "_mask"}, 64'(viol_mask), 64'(m));
    check({tag, "_count"}, 64'(viol_count), 64'($countones(m)));
    check({tag, "_alarm"}, 64'(alarm), 64'($countones(m) >= 1));
    check({tag, "_target"}, 64'(alarm_target), 64'(exp_tgt_q.pop_front()));
    check({tag, "_windows"}, 64'(windows_seen), 64'(windows_m));
    @(negedge clk_h);
    cyc++;
    if (cyc >= hold) enable_detect = 1'b0;
    check({tag, "_end_drop"}, 64'(end_detect), 64'd0);
    while (cyc < hold) begin
      @(negedge clk_h);
      cyc++;
    end
    enable_detect = 1'b0;
    repeat (2) @(negedge clk_h);
    check({tag, "_idle"}, 64'(busy), 64'd0);
    check({tag, "_one_pulse"}, 64'(end_cnt - ends_before), 64'd1);
  endtask

  task automatic run_plain(input string tag, input logic [1:0] tgt);
    run_window(tag, tgt, 1, 0, 0, 0, '0, '0, 1'b0);
  endtask

  initial begin
    int ends_before;
    reset_model();
    for (int i = 0; i < N; i++) hpm_v[i] = {$urandom, $urandom};

    // Reset with random inputs
    rst_h = 1'b0;
    repeat (5) begin
      @(negedge clk_h);
      enable_detect = 1'($urandom_range(0, 1));
      hpm_in[63:0] = {$urandom, $urandom};
      target = 2'($urandom_range(0, 3));
      cfg_we = 1'($urandom_range(0, 1));
      cfg_idx = 5'($urandom_range(0, 31));
    end
    check("rst_end", 64'(end_detect), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_alarm", 64'(alarm), 64'd0);
    check("rst_mask", 64'(viol_mask), 64'd0);
    check("rst_count", 64'(viol_count), 64'd0);
    check("rst_target", 64'(alarm_target), 64'd0);
    check("rst_windows", 64'(windows_seen), 64'd0);
    enable_detect = 1'b0; cfg_we = 1'b0;
    @(negedge clk_h);
    rst_h = 1'b1;
    repeat (20) @(negedge clk_h);
    check("rst_no_end", 64'(end_cnt), 64'd0);
    check("rst_idle_busy", 64'(busy), 64'd0);

    // Directed in-range / violation / saturation
    cfg_write(2, 32'd100, 32'd200, 1'b1);
    hpm_v[2] = 64'd150;
    run_plain("inrange", 2'b01);
    hpm_v[2] = 64'd201;
    run_plain("viol_hi", 2'b10);
    hpm_v[2] = 64'd99;
    run_plain("viol_lo", 2'b10);
    hpm_v[2] = 64'h1_0000_0000;
    run_plain("sat_viol", 2'b11);
    cfg_write(2, 32'd100, 32'hFFFF_FFFF, 1'b1);
    run_plain("sat_ok", 2'b00);
    cfg_write(2, 32'd100, 32'd200, 1'b1);

    // Write coinciding with trigger: scan uses old bounds, next scan the new ones
    hpm_v[2] = 64'd150;
    run_window("cfg_e0", 2'b01, 1, 1, 0, 2, 32'd0, 32'd0, 1'b1);
    run_plain("cfg_e0_after", 2'b01);
    cfg_write(2, 32'd100, 32'd200, 1'b1);
    cfg_write(N, 32'd0, 32'd0, 1'b1);
    run_plain("cfg_oob", 2'b10);

    // Held enable with a cfg write during the scan
    run_window("hold40", 2'b11, 40, 0, 1, 2, 32'd0, 32'd0, 1'b1);
    run_plain("rearm", 2'b01);

    // Randomized windows
    for (int w = 0; w < 10; w++) begin
      for (int i = 0; i < N; i++) begin
        logic [31:0] a, b;
        a = $urandom_range(0, 1000);
        b = $urandom_range(0, 1000);
        if ($urandom_range(0, 4) != 0 && a > b) begin
          logic [31:0] t;
          t = a; a = b; b = t;
        end
        if ($urandom_range(0, 3) == 0) cfg_write(i, a, b, 1'($urandom_range(0, 1)));
        case ($urandom_range(0, 4))
          0: hpm_v[i] = {32'd0, lo_m[i]};
          1: hpm_v[i] = {32'd0, hi_m[i] + 32'd1};
          2: hpm_v[i] = {32'($urandom_range(0, 2)), 32'($urandom_range(0, 1100))};
          3: hpm_v[i] = {32'd0, hi_m[i]};
          default: hpm_v[i] = {32'd0, lo_m[i] - 32'd1};
        endcase
      end
      run_window($sformatf("rand%0d", w), 2'($urandom_range(0, 3)), $urandom_range(1, 3),
                 0, 0, 0, '0, '0, 1'b0);
    end

    // Reset in the middle of a scan
    cfg_write(2, 32'd100, 32'd200, 1'b1);
    hpm_v[2] = 64'd5;
    ends_before = end_cnt;
    @(negedge clk_h);
    for (int i = 0; i < N; i++) hpm_in[i*64 +: 64] = hpm_v[i];
    enable_detect = 1'b1;
    @(negedge clk_h);
    enable_detect = 1'b0;
    repeat (4) @(negedge clk_h);
    #2 rst_h = 1'b0;
    #1;
    check("midrst_mask", 64'(viol_mask), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_windows", 64'(windows_seen), 64'd0);
    @(negedge clk_h);
    rst_h = 1'b1;
    reset_model();
    repeat (20) @(negedge clk_h);
    check("midrst_no_end", 64'(end_cnt - ends_before), 64'd0);
    run_plain("post_rst", 2'b10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
